// File: rtl/dac8568_seq.sv
// dac8568_seq: DAC8568 loader with built-in SPI serializer.
// Runs the init words (software reset, internal reference on, power-up of
// channels 0..NCH-1). Afterwards it writes channel codes on request, sending
// only the channels whose code changed since their last write, or every
// channel when a forced refresh is requested.
//
// Handshake: start and update are single-cycle pulses. They need no ready.
// start is honoured only in IDLE; it is dropped otherwise. update is never
// lost. It runs at once when the block is IDLE and initialised. Otherwise it
// is held in a one-deep pending slot. Repeat updates merge into that slot,
// and force is ORed into it.
//
// The channel-write request input is named force_all, because "force" is a
// reserved word in SystemVerilog. dbg_state exposes the sequencer state.
module dac8568_seq #(
  parameter int NCH     = 8,
  parameter int CLK_DIV = 2,
  parameter int SYNC_HI = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               update,
  input  logic               force_all,
  input  logic [16*NCH-1:0]  data,
  output logic               busy,
  output logic               init_done,
  output logic               upd_done,
  output logic               din,
  output logic               sclk,
  output logic               syn,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_INIT_SWRST = 3'd1,
    ST_INIT_REF   = 3'd2,
    ST_INIT_PWR   = 3'd3,
    ST_SCAN       = 3'd4,
    ST_SEND_CH    = 3'd5,
    ST_FINISH     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_SHIFT = 2'd1,
    SER_GAP   = 2'd2
  } ser_t;

  localparam int          MASK_I    = (1 << NCH) - 1;
  localparam logic [7:0]  PWR_MASK  = MASK_I[7:0];
  localparam logic [31:0] W_SWRST   = 32'h0700_0000;
  localparam logic [31:0] W_REF     = 32'h090A_0000;
  localparam logic [31:0] W_PWR     = {24'h040000, PWR_MASK};
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(SYNC_HI - 1);

  // Sequencer state and per-channel bookkeeping.
  state_t            r_state;
  state_t            w_nxt;
  logic              r_init_done;
  logic              r_pend;
  logic              r_pend_force;
  logic              r_force_cur;
  logic [2:0]        r_ch;
  logic [15:0]       r_snap   [NCH];
  logic [15:0]       r_shadow [NCH];
  logic [NCH-1:0]    r_shadow_vld;

  // Serializer state.
  ser_t              r_ser_st;
  logic [15:0]       r_div_cnt;
  logic [15:0]       r_gap_cnt;
  logic [4:0]        r_bit_cnt;
  logic [31:0]       r_shift;
  logic              r_sclk;
  logic              r_syn;

  // Control strobes decoded by the sequencer.
  logic              w_go;
  logic [31:0]       w_word;
  logic              w_ser_done;
  logic              w_run_upd;
  logic              w_start_acc;
  logic              w_shadow_wr;
  logic              w_init_fin;
  logic              w_hit;
  logic [2:0]        w_hit_ch;
  logic [15:0]       w_hit_code;
  logic [3:0]        w_from;
  logic [31:0]       w_ch_word;

  // The frame is done on the last cycle of the syn-high gap. The next frame may load on that same edge.
  assign w_ser_done = (r_ser_st == SER_GAP) && (r_gap_cnt == GAP_LAST);

  // Serializer. Load a word on go. sclk toggles every CLK_DIV cycles. Data advances on each rise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ser_st  <= SER_IDLE;
      r_div_cnt <= '0;
      r_gap_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_sclk    <= 1'b1;
      r_syn     <= 1'b1;
    end else if (w_go) begin
      r_ser_st  <= SER_SHIFT;
      r_div_cnt <= '0;
      r_gap_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= w_word;
      r_sclk    <= 1'b1;
      r_syn     <= 1'b0;
    end else begin
      case (r_ser_st)
        SER_SHIFT: begin
          if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            if (r_sclk) begin
              r_sclk <= 1'b0;
            end else if (r_bit_cnt == 5'd31) begin
              r_ser_st  <= SER_GAP;
              r_sclk    <= 1'b1;
              r_syn     <= 1'b1;
              r_shift   <= '0;
              r_gap_cnt <= '0;
            end else begin
              r_sclk    <= 1'b1;
              r_bit_cnt <= r_bit_cnt + 5'd1;
              r_shift   <= {r_shift[30:0], 1'b0};
            end
          end else begin
            r_div_cnt <= r_div_cnt + 16'd1;
          end
        end
        SER_GAP: begin
          if (r_gap_cnt == GAP_LAST) r_ser_st <= SER_IDLE;
          else                       r_gap_cnt <= r_gap_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign din  = r_shift[31];
  assign sclk = r_sclk;
  assign syn  = r_syn;

  // Find the lowest channel at or above w_from that needs a write.
  always_comb begin
    logic need;
    w_hit      = 1'b0;
    w_hit_ch   = '0;
    w_hit_code = '0;
    w_from     = (r_state == ST_SEND_CH) ? ({1'b0, r_ch} + 4'd1) : 4'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      need = r_force_cur | ~r_shadow_vld[i] | (r_snap[i] != r_shadow[i]);
      if (need && (4'(i) >= w_from)) begin
        w_hit      = 1'b1;
        w_hit_ch   = 3'(i);
        w_hit_code = r_snap[i];
      end
    end
  end

  assign w_ch_word = {8'h03, 1'b0, w_hit_ch, w_hit_code, 4'h0};

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  // Sequencer next state and frame launch decisions.
  always_comb begin
    w_nxt       = r_state;
    w_go        = 1'b0;
    w_word      = '0;
    w_run_upd   = 1'b0;
    w_start_acc = 1'b0;
    w_shadow_wr = 1'b0;
    w_init_fin  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nxt       = ST_INIT_SWRST;
          w_go        = 1'b1;
          w_word      = W_SWRST;
          w_start_acc = 1'b1;
        end else if (r_init_done && (update || r_pend)) begin
          w_nxt     = ST_SCAN;
          w_run_upd = 1'b1;
        end
      end
      ST_INIT_SWRST: begin
        if (w_ser_done) begin
          w_nxt  = ST_INIT_REF;
          w_go   = 1'b1;
          w_word = W_REF;
        end
      end
      ST_INIT_REF: begin
        if (w_ser_done) begin
          w_nxt  = ST_INIT_PWR;
          w_go   = 1'b1;
          w_word = W_PWR;
        end
      end
      ST_INIT_PWR: begin
        if (w_ser_done) begin
          w_nxt      = ST_IDLE;
          w_init_fin = 1'b1;
        end
      end
      ST_SCAN: begin
        if (w_hit) begin
          w_nxt  = ST_SEND_CH;
          w_go   = 1'b1;
          w_word = w_ch_word;
        end else begin
          w_nxt = ST_FINISH;
        end
      end
      ST_SEND_CH: begin
        if (w_ser_done) begin
          w_shadow_wr = 1'b1;
          if (w_hit) begin
            w_go   = 1'b1;
            w_word = w_ch_word;
          end else begin
            w_nxt = ST_FINISH;
          end
        end
      end
      ST_FINISH: w_nxt = ST_IDLE;
      default:   w_nxt = ST_IDLE;
    endcase
  end

  // Init flag, pending update slot, data snapshot, and per-channel shadows.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_init_done  <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_force <= 1'b0;
      r_force_cur  <= 1'b0;
      r_ch         <= '0;
      r_shadow_vld <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_snap[i]   <= '0;
        r_shadow[i] <= '0;
      end
    end else begin
      if (w_start_acc) begin
        r_init_done  <= 1'b0;
        r_shadow_vld <= '0;
      end
      if (w_init_fin) r_init_done <= 1'b1;

      if (w_run_upd) begin
        r_pend       <= 1'b0;
        r_pend_force <= 1'b0;
        r_force_cur  <= (update & force_all) | r_pend_force;
        for (int i = 0; i < NCH; i++) r_snap[i] <= data[16*i +: 16];
      end else if (update) begin
        r_pend       <= 1'b1;
        r_pend_force <= r_pend_force | force_all;
      end

      if (w_go && ((r_state == ST_SCAN) || (r_state == ST_SEND_CH))) r_ch <= w_hit_ch;

      if (w_shadow_wr) begin
        for (int i = 0; i < NCH; i++) begin
          if (3'(i) == r_ch) begin
            r_shadow[i]     <= r_snap[i];
            r_shadow_vld[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign busy      = (r_state != ST_IDLE) && (r_state != ST_FINISH);
  assign upd_done  = (r_state == ST_FINISH);
  assign init_done = r_init_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dac8568_seq.sv
// Bench for dac8568_seq with NCH=4, CLK_DIV=2, SYNC_HI=4. A monitor captures
// frames on sclk falls. Each frame is checked against a queue of expected words.
module tb_dac8568_seq;
  localparam int NCH     = 4;
  localparam int CLK_DIV = 2;
  localparam int SYNC_HI = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              update;
  logic              force_all;
  logic [16*NCH-1:0] data;
  logic              busy;
  logic              init_done;
  logic              upd_done;
  logic              din;
  logic              sclk;
  logic              syn;
  logic [2:0]        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  dac8568_seq #(.NCH(NCH), .CLK_DIV(CLK_DIV), .SYNC_HI(SYNC_HI)) dut (
    .clk(clk), .reset(reset), .start(start), .update(update),
    .force_all(force_all), .data(data), .busy(busy), .init_done(init_done),
    .upd_done(upd_done), .din(din), .sclk(sclk), .syn(syn),
    .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // frame monitor / scoreboard
  int          mon_bits = 0;
  int          mon_gap  = 0;
  logic [31:0] mon_word = '0;
  logic        mon_in   = 1'b0;
  logic        mon_seen = 1'b0;
  logic        p_syn    = 1'b1;
  logic        p_sclk   = 1'b1;
  int          n_upd    = 0;

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      mon_in   = 1'b0;
      mon_bits = 0;
      mon_seen = 1'b0;
      mon_gap  = 0;
    end else begin
      if (p_syn === 1'b1 && syn === 1'b0) begin
        if (mon_seen) check("syn_gap", 32'(mon_gap >= SYNC_HI), 32'd1);
        mon_in   = 1'b1;
        mon_bits = 0;
        mon_word = '0;
      end
      if (mon_in && p_sclk === 1'b1 && sclk === 1'b0) begin
        mon_word = {mon_word[30:0], din};
        mon_bits++;
      end
      if (mon_in && p_syn === 1'b0 && syn === 1'b1) begin
        mon_in   = 1'b0;
        mon_seen = 1'b1;
        mon_gap  = 0;
        check("frame_bits", 32'(mon_bits), 32'd32);
        if (exp_q.size() == 0) check("frame_unexpected", 32'(exp_q.size()), 32'd1);
        else                   check("frame_word", mon_word, exp_q.pop_front());
      end
      if (syn === 1'b1) mon_gap++;
      if (upd_done === 1'b1) n_upd++;
    end
    p_syn  = syn;
    p_sclk = sclk;
  end

  // driver tasks
  task automatic set_ch(input int i, input logic [15:0] v);
    data[16*i +: 16] = v;
  endtask

  task automatic pulse_update(input logic f);
    update    = 1'b1;
    force_all = f;
    @(negedge clk);
    update    = 1'b0;
    force_all = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_init(input string tag, output int cyc);
    cyc = 1;
    while (init_done !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, 32'(init_done), 32'd1);
  endtask

  task automatic wait_upd(input string tag, output int cyc);
    cyc = 1;
    while (upd_done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, 32'(upd_done), 32'd1);
  endtask

  task automatic finish_upd(input string tag);
    int cyc;
    wait_upd({tag, "_done"}, cyc);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_pulse1"}, 32'(upd_done), 32'd0);
    check({tag, "_qempty"}, 32'(exp_q.size()), 32'd0);
  endtask

  int cyc;
  int base;
  int t;

  initial begin
    reset = 1'b0; start = 1'b0; update = 1'b0; force_all = 1'b0; data = '0;
    repeat (3) @(negedge clk);
    check("rst_syn", 32'(syn), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd1);
    check("rst_din", 32'(din), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_upd_done", 32'(upd_done), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // init sequence
    exp_q.push_back(32'h0700_0000);
    exp_q.push_back(32'h090A_0000);
    exp_q.push_back(32'h0400_000F);
    pulse_start();
    wait_init("init_done", cyc);
    check("init_latency", 32'(cyc), 32'd397);
    check("init_busy", 32'(busy), 32'd0);
    check("init_qempty", 32'(exp_q.size()), 32'd0);

    // first update writes every channel (shadows invalid)
    set_ch(0, 16'h1234); set_ch(1, 16'hABCD); set_ch(2, 16'h0000); set_ch(3, 16'hFFFF);
    exp_q.push_back(32'h0301_2340);
    exp_q.push_back(32'h031A_BCD0);
    exp_q.push_back(32'h0320_0000);
    exp_q.push_back(32'h033F_FFF0);
    pulse_update(1'b0);
    wait_upd("upd4_done", cyc);
    check("upd4_latency", 32'(cyc), 32'd530);
    check("upd4_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("upd4_pulse1", 32'(upd_done), 32'd0);
    check("upd4_qempty", 32'(exp_q.size()), 32'd0);

    // only ch2 changed
    set_ch(2, 16'h8001);
    exp_q.push_back(32'h0328_0010);
    pulse_update(1'b0);
    finish_upd("upd1");

    // nothing changed: zero frames
    pulse_update(1'b0);
    wait_upd("upd0_done", cyc);
    check("upd0_latency", 32'(cyc), 32'd2);
    repeat (200) @(negedge clk);
    check("upd0_qempty", 32'(exp_q.size()), 32'd0);

    // forced refresh
    exp_q.push_back(32'h0301_2340);
    exp_q.push_back(32'h031A_BCD0);
    exp_q.push_back(32'h0328_0010);
    exp_q.push_back(32'h033F_FFF0);
    pulse_update(1'b1);
    finish_upd("force");

    // two updates while busy collapse into one follow-up
    base = n_upd;
    exp_q.push_back(32'h0301_2340);
    exp_q.push_back(32'h031A_BCD0);
    exp_q.push_back(32'h0328_0010);
    exp_q.push_back(32'h033F_FFF0);
    exp_q.push_back(32'h0310_F0F0);
    pulse_update(1'b1);
    repeat (100) @(negedge clk);
    pulse_update(1'b0);
    repeat (100) @(negedge clk);
    set_ch(1, 16'h0F0F);
    pulse_update(1'b0);
    wait_upd("dbl_first", cyc);
    @(negedge clk);
    wait_upd("dbl_second", cyc);
    repeat (400) @(negedge clk);
    check("dbl_upd_count", 32'(n_upd - base), 32'd2);
    check("dbl_qempty", 32'(exp_q.size()), 32'd0);

    // reset in the middle of a frame
    pulse_update(1'b1);
    t = 0;
    while (mon_bits != 17 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("bit17_reached", 32'(mon_bits), 32'd17);
    reset = 1'b0;
    @(negedge clk);
    check("mid_syn", 32'(syn), 32'd1);
    check("mid_sclk", 32'(sclk), 32'd1);
    check("mid_din", 32'(din), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_init_done", 32'(init_done), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // update without init stays pending, no frames
    pulse_update(1'b0);
    repeat (600) @(negedge clk);
    check("pend_busy", 32'(busy), 32'd0);
    check("pend_init_done", 32'(init_done), 32'd0);

    // init then the pending update writes every channel
    exp_q.push_back(32'h0700_0000);
    exp_q.push_back(32'h090A_0000);
    exp_q.push_back(32'h0400_000F);
    exp_q.push_back(32'h0301_2340);
    exp_q.push_back(32'h0310_F0F0);
    exp_q.push_back(32'h0328_0010);
    exp_q.push_back(32'h033F_FFF0);
    pulse_start();
    wait_init("reinit_done", cyc);
    check("reinit_latency", 32'(cyc), 32'd397);
    finish_upd("pend");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
